// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan driver.
// All codes are active-low, segment order {g,f,e,d,c,b,a}.
package seg7_pkg;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to active-low seven-segment decode; non-BCD values show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit seven-segment driver with a per-frame snapshot,
// leading-zero blanking and a one-cycle anode-off guard at each digit change.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        enable_in,
  input  logic [15:0] digit_in,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en_in,
  output logic [6:0]  seg_out,
  output logic [3:0]  an_out,
  output logic        dp_out
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0]                div_cnt;
  logic [1:0]                   scan_idx;
  logic [NUM_DIGITS-1:0][3:0]   snap_dig;
  logic [NUM_DIGITS-1:0]        snap_dp;

  logic       tick, frame_start, blank;
  logic [3:0] cur_dig;
  logic [6:0] dec_seg, seg_nxt;
  logic [3:0] an_nxt;
  logic       dp_nxt;

  assign tick        = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_start = (div_cnt == '0) && (scan_idx == 2'd0);
  assign cur_dig     = snap_dig[scan_idx];

  bcd_to_seg7 u_dec (.bcd(cur_dig), .seg(dec_seg));

  // A digit is blanked only if it and every more-significant digit are zero.
  always_comb begin
    blank = 1'b0;
    if (lzb_en_in) begin
      case (scan_idx)
        2'd3:    blank = (snap_dig[3] == 4'd0);
        2'd2:    blank = (snap_dig[3] == 4'd0) && (snap_dig[2] == 4'd0);
        2'd1:    blank = (snap_dig[3] == 4'd0) && (snap_dig[2] == 4'd0) &&
                         (snap_dig[1] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    seg_nxt = blank ? SEG_BLANK : dec_seg;
    an_nxt  = AN_OFF;
    if (enable_in && (div_cnt != '0))
      an_nxt = AN_OFF ^ (4'b0001 << scan_idx);
    dp_nxt  = (an_nxt == AN_OFF) ? 1'b1 : ~snap_dp[scan_idx];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      div_cnt  <= '0;
      scan_idx <= 2'd0;
      snap_dig <= '0;
      snap_dp  <= '0;
      seg_out  <= SEG_BLANK;
      an_out   <= AN_OFF;
      dp_out   <= 1'b1;
    end else begin
      seg_out <= seg_nxt;
      an_out  <= an_nxt;
      dp_out  <= dp_nxt;
      if (enable_in) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick)
          scan_idx <= scan_idx + 2'd1;
        // Snapshot only at frame start so one frame never mixes two values.
        if (frame_start) begin
          snap_dig <= digit_in;
          snap_dp  <= dp_in;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench: directed scenarios plus random stimulus against a frame-position model.
module tb_seg7_scan_mux;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        enable_in = 1'b0;
  logic [15:0] digit_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lzb_en_in = 1'b0;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        dp_out;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: position within the frame plus the latched frame contents.
  int         pos;
  int         snap [4];
  logic [3:0] sdp;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_dp;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  logic [6:0] exp1234 [4]  = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  seg7_scan_mux #(.SCAN_DIV(DIV)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
    .digit_in(digit_in), .dp_in(dp_in), .lzb_en_in(lzb_en_in),
    .seg_out(seg_out), .an_out(an_out), .dp_out(dp_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs after this edge, from the state before it.
  task automatic model_edge();
    int  idx, dv;
    bit  blank;
    if (reset_in) begin
      pos = 0;
      for (int j = 0; j < 4; j++) snap[j] = 0;
      sdp   = 4'h0;
      e_seg = 7'h7F;
      e_an  = 4'hF;
      e_dp  = 1'b1;
    end else begin
      idx   = pos / DIV;
      dv    = pos % DIV;
      blank = lzb_en_in && (idx > 0);
      for (int j = idx; j < 4; j++)
        if (snap[j] != 0) blank = 1'b0;
      if (blank)            e_seg = 7'h7F;
      else if (snap[idx] > 9) e_seg = 7'h3F;
      else                  e_seg = seg_tbl[snap[idx]];
      e_an = (!enable_in || dv == 0) ? 4'hF : (4'hF ^ (4'b0001 << idx));
      e_dp = (e_an == 4'hF) ? 1'b1 : ~sdp[idx];
      if (enable_in) begin
        if (pos == 0) begin
          for (int j = 0; j < 4; j++) snap[j] = int'(digit_in[4*j +: 4]);
          sdp = dp_in;
        end
        pos = (pos + 1) % FRAME;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    check("seg", {9'h0, seg_out}, {9'h0, e_seg});
    check("an",  {12'h0, an_out}, {12'h0, e_an});
    check("dp",  {15'h0, dp_out}, {15'h0, e_dp});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_digits(output logic [15:0] d);
    int r;
    for (int j = 0; j < 4; j++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       d[4*j +: 4] = 4'd0;
      else if (r < 13) d[4*j +: 4] = 4'($urandom_range(1, 9));
      else             d[4*j +: 4] = 4'($urandom_range(10, 15));
    end
  endtask

  initial begin
    int guard;
    bit found;
    logic [15:0] rd;

    // Reset held for three edges
    reset_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_seg", {9'h0, seg_out}, 16'h007F);
      check("rst_an",  {12'h0, an_out}, 16'h000F);
    end

    // Basic scan of 1234 with dp on digit 0
    reset_in = 1'b0; enable_in = 1'b1; digit_in = 16'h1234; dp_in = 4'b0001;
    step();
    check("first_ghost_an", {12'h0, an_out}, 16'h000F);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        check("scan_an",  {12'h0, an_out}, {12'h0, 4'hF ^ (4'b0001 << d)});
        check("scan_seg", {9'h0, seg_out}, {9'h0, exp1234[d]});
        check("scan_dp",  {15'h0, dp_out}, {15'h0, (d == 0) ? 1'b0 : 1'b1});
      end
      step();
      check("ghost_an", {12'h0, an_out}, 16'h000F);
    end

    // Input change mid-frame must not tear the current frame
    guard = 0;
    while (pos / DIV != 2 && guard < FRAME) begin step(); guard++; end
    digit_in = 16'h5678;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (an_out == 4'b1011) begin
        found = 1'b1;
        check("tear_seg", {9'h0, seg_out}, 16'h0024);
      end
    end
    check("tear_digit2_seen", {15'h0, found}, 16'h0001);
    run(2 * FRAME);

    // Leading-zero blanking on/off, and invalid digit dash
    digit_in = 16'h0070; dp_in = 4'h0; lzb_en_in = 1'b1;
    run(2 * FRAME);
    lzb_en_in = 1'b0;
    run(2 * FRAME);
    digit_in = 16'h00A0; lzb_en_in = 1'b1;
    run(2 * FRAME);
    digit_in = 16'h0000;
    run(2 * FRAME);

    // Freeze mid-dwell then resume
    digit_in = 16'h9081; dp_in = 4'b1010;
    guard = 0;
    while (!(pos / DIV == 1 && pos % DIV == 2) && guard < 2 * FRAME) begin step(); guard++; end
    enable_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("freeze_an", {12'h0, an_out}, 16'h000F);
    end
    enable_in = 1'b1;
    run(2 * FRAME);

    // Reset during digit 3
    guard = 0;
    while (!(pos / DIV == 3 && pos % DIV == 2) && guard < 2 * FRAME) begin step(); guard++; end
    reset_in = 1'b1;
    step();
    check("midrst_an",  {12'h0, an_out}, 16'h000F);
    check("midrst_seg", {9'h0, seg_out}, 16'h007F);
    reset_in = 1'b0;
    run(2 * FRAME);

    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin rand_digits(rd); digit_in = rd; end
      if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) lzb_en_in = ~lzb_en_in;
      enable_in = ($urandom_range(0, 7) != 0);
      reset_in  = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter SCAN_DIV, default 4, SHALL set clock cycles per digit dwell; legal range 2..65535.
REQ-002 clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_in  input  1  reset, synchronous, active-high.
REQ-004 enable_in  input  1  1 = scan running; 0 = scan frozen and display dark.
REQ-005 digit_in  input  16  four BCD digits; digit i = digit_in[4i+3:4i], digit 0 least significant; each digit is one mod-10 counter count_out.
REQ-006 dp_in  input  4  decimal point per digit, 1 = lit.
REQ-007 lzb_en_in  input  1  1 = leading-zero blanking on.
REQ-008 seg_out  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-009 an_out  output  4  active-low digit select; an_out[i]=0 drives digit i.
REQ-010 dp_out  output  1  active-low decimal point.

Function
REQ-011 Prescaler div_cnt SHALL count 0..SCAN_DIV-1 while enable_in=1 and wrap to 0; tick = (div_cnt==SCAN_DIV-1).
REQ-012 Scan index scan_idx (0..3) SHALL increment on tick and wrap 3->0; one frame = 4*SCAN_DIV cycles.
REQ-013 Snapshot registers SHALL load digit_in and dp_in at the end of every cycle with enable_in=1, div_cnt==0 and scan_idx==0; they SHALL hold at all other times (tear-free frame).
REQ-014 All outputs SHALL be registered; the value in cycle t+1 SHALL be the decode of div_cnt, scan_idx and the snapshot as they are in cycle t.
REQ-015 Ghost guard: an_out SHALL decode to 4'b1111 whenever the source div_cnt==0.
REQ-016 Otherwise an_out SHALL be all-ones except bit scan_idx = 0.
REQ-017 seg_out codes for 0..9 SHALL be 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-018 Snapshot digit values 10..15 SHALL display dash 0111111.
REQ-019 Blank code 1111111 SHALL be used when lzb_en_in=1 and:
 - digit 3 == 0; or
 - digit 2 with digits 3..2 == 0; or
 - digit 1 with digits 3..1 == 0.
 Digit 0 SHALL never be blanked. Invalid (>9) digits count as non-zero.
REQ-020 dp_out SHALL be ~snapshot dp of scan_idx, forced 1 when an_out is 4'b1111.
REQ-021 enable_in=0 SHALL hold div_cnt, scan_idx and snapshot, and SHALL force an_out=1111 and dp_out=1 from the next cycle. On re-enable, the scan SHALL resume from the held state.
REQ-022 lzb_en_in SHALL be sampled live, not snapshotted.

Reset
REQ-023 reset_in=1 at a rising edge SHALL set div_cnt=0, scan_idx=0, snapshot digits and dp to 0, seg_out=1111111, an_out=1111 and dp_out=1.
REQ-024 Reset SHALL override enable_in and take effect mid-frame; the first cycle after release SHALL load the snapshot per REQ-013.

Structure
REQ-025 Package seg7_pkg SHALL hold the ten digit codes, SEG_BLANK=1111111, SEG_DASH=0111111 and AN_OFF=1111.
REQ-026 Combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out, dash for >9) SHALL perform the segment decode.

Verification (SCAN_DIV=4)
REQ-027 Reset held 3 cycles -> seg_out=1111111, an_out=1111, dp_out=1 throughout.
REQ-028 digit_in=16'h1234, dp_in=0001, lzb=0, release reset -> per dwell: 1 cycle an_out=1111, then 3 cycles of the digit:
 - an_out=1110, seg_out=0011001, dp_out=0;
 - an_out=1101, seg_out=0110000;
 - an_out=1011, seg_out=0100100;
 - an_out=0111, seg_out=1111001;
 - then repeat.
REQ-029 Change digit_in from 16'h1234 to 16'h5678 while scan_idx=2 -> digits 2 and 3 still show 2 and 1; 5678 appears from the next frame start.
REQ-030 digit_in=16'h0070, lzb=1 -> digits 3 and 2 show 1111111 with their anodes active, digit 1 shows 1111000, digit 0 shows 1000000. With lzb=0, digits 3 and 2 show 1000000.
REQ-031 digit_in=16'h00A0 -> digit 1 shows 0111111.
REQ-032 enable_in=0 for 5 cycles mid-dwell -> an_out=1111 and div_cnt/scan_idx unchanged; on re-enable the dwell completes its remaining cycles. Reset at scan_idx=3 -> outputs reset next cycle and the scan restarts at digit 0.
